dot_product_mac: RTL and testbench
==================================

# dot_product_mac

Sequential multiply-accumulate stage that sits directly downstream of `mult8x8_struct`. It accepts a stream of unsigned 8-bit operand pairs over a valid/ready handshake and feeds each pair to an internal `mult8x8_struct` instance. It accumulates LEN consecutive 16-bit products into one unsigned dot-product result, then presents that result on a valid/ready output port.

## Interface
Parameters:
- `LEN`, default 4: number of operand pairs per result; legal range 1..255.
- `ACC_W`, default 20: accumulator/result width. Must satisfy ACC_W ≥ 16 + ceil(log2(LEN)); violation is an elaboration error.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `in_valid` input 1: operand pair present.
- `in_ready` output 1: block can accept a pair.
- `a` input 8: operand A, unsigned.
- `b` input 8: operand B, unsigned.
- `out_valid` output 1: result present.
- `out_ready` input 1: downstream accepts the result.
- `out_data` output ACC_W: dot-product result, unsigned.

## Operation
- An input beat is accepted on an edge where `in_valid && in_ready`.
- Stage 1: on acceptance, register the product `p = a*b` (16 bit, from `mult8x8_struct`) into `prod_q` and set `prod_v`.
- Stage 2: when `prod_v` is set, update `acc <= (first ? 0 : acc) + prod_q`, zero-extended to ACC_W.
  - `first` flags the first product of a set.
  - No wrap can occur when the ACC_W constraint holds.
- `cnt` counts accepted beats, 0..LEN-1.
  - It holds during `in_valid` gaps.
  - It resets to 0 when the LEN-th beat is accepted.
- FSM states:
  - `ST_ACC`: `in_ready=1`. Accepting beat LEN → `ST_FLUSH`.
  - `ST_FLUSH`: `in_ready=0`. The last product is added into `acc` this cycle → `ST_DONE`.
  - `ST_DONE`: `in_ready=0`, `out_valid=1`, `out_data=acc`. An edge with `out_ready=1` → `ST_ACC`, and the next set starts from zero.
- `out_data` is stable while `out_valid && !out_ready`.
- `in_valid` asserted during `ST_FLUSH` or `ST_DONE` is ignored: no beat is accepted and nothing is lost upstream, because `in_ready=0`.
- LEN=1: each accepted beat goes straight to `ST_FLUSH`.

## Timing
- Reset (any edge with `rst_n=0`):
  - state=`ST_ACC`; `cnt`, `acc`, `prod_q`, `prod_v` and `first` are all cleared (`first` is set to 1).
  - `out_valid=0`, `out_data=0`.
  - `in_ready` is forced to 0 while `rst_n=0` and is 1 from the first cycle after release.
- Reset mid-operation discards any partial sum and any pending result. `out_valid` is 0 in the cycle after the reset edge.
- Latency: if the last beat is accepted at edge E0, `acc` holds the final value after E0+1. `out_valid` rises in the cycle after E0+1, i.e. 2 cycles after the last handshake.
- Throughput: with zero-bubble input and `out_ready` held at 1, one result every LEN+2 cycles. `in_ready` is high again in the cycle after the output handshake.
- `in_ready` and `out_valid` are pure functions of the registered state (plus `rst_n`); there is no combinational path from `in_valid` or `out_ready`.

## Structure
- Package `mac_pkg`:
  - state encoding `ST_ACC`, `ST_FLUSH`, `ST_DONE`;
  - `PROD_W = 16`;
  - a clog2 helper for the ACC_W check.
- Sub-module: one `mult8x8_struct` instance, combinational, driving stage 1.
- Everything else (FSM, counter, product register, accumulator) lives in `dot_product_mac`.

## Test plan
- LEN=4, out_ready=1, back-to-back beats (1,1),(2,3),(4,5),(6,7) → `out_data`=69; `out_valid` high for exactly 1 cycle, 2 cycles after the 4th handshake; next result after LEN+2 cycles.
- LEN=4, four beats (255,255) → `out_data`=260100 (0x3F804), no truncation at ACC_W=20.
- Backpressure: hold `out_ready=0` for 5 cycles with `in_valid=1` → `out_valid` stays 1 and `out_data` stays 69; `in_ready`=0 and no beats are consumed; after release, the next set (1,1)×4 → 4, with no carry-over from the previous sum.
- Random `in_valid` bubbles (0–3 idle cycles) on the scenario-1 operands → `out_data`=69, and `cnt` never advances on idle cycles.
- Pull `rst_n` low for 1 cycle after 2 accepted beats → `out_valid`=0, `in_ready`=0 during reset; after release, (1,1)×4 → 4.
- LEN=1: beats (0,200) then (17,15) → results 0 then 255, each 2 cycles after its handshake.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and constants for the dot-product multiply-accumulate stage.
package mac_pkg;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int PROD_W = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mult8x8_struct.sv
// Combinational unsigned 8x8 multiplier built from shifted partial products.
module mult8x8_struct
  import mac_pkg::*;
(
  input  logic [7:0]        a,
  input  logic [7:0]        b,
  output logic [PROD_W-1:0] p
);

  logic [PROD_W-1:0] pp [8];

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      pp[i] = b[i] ? (PROD_W'(a) << i) : '0;
    end
  end

  always_comb begin
    p = '0;
    for (int i = 0; i < 8; i++) begin
      p = p + pp[i];
    end
  end

endmodule

// File: rtl/dot_product_mac.sv
// Accumulates LEN unsigned 8x8 products into one result, with a one-stage
// product register ahead of the accumulator and valid/ready on both sides.
module dot_product_mac
  import mac_pkg::*;
#(
  parameter int LEN   = 4,
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data
);

  if (LEN < 1 || LEN > 255) begin : g_bad_len
    $error("dot_product_mac: LEN must be in 1..255");
  end
  if (ACC_W < PROD_W + clog2(LEN)) begin : g_bad_acc_w
    $error("dot_product_mac: ACC_W too narrow for LEN products");
  end

  localparam logic [7:0] LAST_CNT = 8'(LEN - 1);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic              prod_v_q, prod_v_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              first_q, first_d;
  logic [PROD_W-1:0] mult_p;
  logic              accept;

  mult8x8_struct u_mult (
    .a (a),
    .b (b),
    .p (mult_p)
  );

  // Handshake outputs depend only on registered state and reset.
  assign in_ready  = rst_n && (state_q == ST_ACC);
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = acc_q;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    prod_v_d = accept;
    acc_d    = acc_q;
    first_d  = first_q;

    if (accept) begin
      prod_d = mult_p;
      cnt_d  = (cnt_q == LAST_CNT) ? 8'd0 : cnt_q + 8'd1;
    end

    // first_q makes the first product of a set overwrite the previous sum.
    if (prod_v_q) begin
      acc_d   = (first_q ? '0 : acc_q) + ACC_W'(prod_q);
      first_d = 1'b0;
    end

    case (state_q)
      ST_ACC:   if (accept && cnt_q == LAST_CNT) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_ACC;
          first_d = 1'b1;
        end
      end
      default:  state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_ACC;
      cnt_q    <= '0;
      prod_q   <= '0;
      prod_v_q <= 1'b0;
      acc_q    <= '0;
      first_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      prod_v_q <= prod_v_d;
      acc_q    <= acc_d;
      first_q  <= first_d;
    end
  end

endmodule

// File: tb/tb_dot_product_mac.sv
// Directed bench for dot_product_mac: a LEN=4 instance and a LEN=1 instance
// share clock and reset; results are captured by a handshake monitor.
module tb_dot_product_mac;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  a, b;
  logic [19:0] out_data;
  logic        in_valid1, in_ready1, out_valid1, out_ready1;
  logic [7:0]  a1, b1;
  logic [19:0] out_data1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int exp_cnt4 = 0;
  int ov_cnt4 = 0;
  int hs_cnt4 = 0;
  logic [19:0] res_data4[$];
  int          res_cyc4[$];
  logic [19:0] res_data1[$];
  int          res_cyc1[$];

  dot_product_mac #(.LEN(4), .ACC_W(20)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  dot_product_mac #(.LEN(1), .ACC_W(20)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (in_valid && in_ready) hs_cnt4++;
  end

  // Records every output handshake with the cycle index it occurred in.
  always @(negedge clk) begin
    if (out_valid) ov_cnt4++;
    if (out_valid && out_ready) begin
      res_data4.push_back(out_data);
      res_cyc4.push_back(cyc);
    end
    if (out_valid1 && out_ready1) begin
      res_data1.push_back(out_data1);
      res_cyc1.push_back(cyc);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int sel, input logic [7:0] av, input logic [7:0] bv,
                               input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      if (sel == 0) in_valid = 1'b0; else in_valid1 = 1'b0;
      @(posedge clk); #1;
      if (sel == 0) checkOutput("idle_cnt_hold", 32'(u_dut4.cnt_q), exp_cnt4);
    end
    if (sel == 0) begin in_valid = 1'b1; a = av; b = bv; end
    else begin in_valid1 = 1'b1; a1 = av; b1 = bv; end
    n = 0;
    while (((sel == 0) ? in_ready : in_ready1) == 1'b0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) checkOutput("in_ready_timeout", (sel == 0) ? in_ready : in_ready1, 1);
    hs_cyc = cyc;
    if (sel == 0) exp_cnt4 = (exp_cnt4 + 1) % 4;
    @(posedge clk); #1;
  endtask

  task automatic waitResults(input int sel, input int want);
    int n;
    n = 0;
    while (((sel == 0) ? res_data4.size() : res_data1.size()) < want && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (((sel == 0) ? res_data4.size() : res_data1.size()) < want)
      checkOutput("result_timeout", (sel == 0) ? res_data4.size() : res_data1.size(), want);
  endtask

  logic [7:0] ops_a [4] = '{8'd1, 8'd2, 8'd4, 8'd6};
  logic [7:0] ops_b [4] = '{8'd1, 8'd3, 8'd5, 8'd7};
  int gaps [4] = '{2, 0, 3, 1};

  initial begin
    int base, base1, hs1, hs2, ov0, h0, ha, hb;
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; out_ready1 = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_in_ready_len1", in_ready1, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    #1;
    checkOutput("release_in_ready", in_ready, 1);

    // Two back-to-back sets with out_ready held high.
    base = res_data4.size();
    ov0 = ov_cnt4;
    for (int i = 0; i < 4; i++) applyStimulus(0, ops_a[i], ops_b[i], 0);
    hs1 = hs_cyc;
    for (int i = 0; i < 4; i++) applyStimulus(0, ops_a[i], ops_b[i], 0);
    hs2 = hs_cyc;
    in_valid = 1'b0;
    waitResults(0, base + 2);
    @(posedge clk); @(posedge clk); #1;
    if (res_data4.size() >= base + 2) begin
      checkOutput("s1_data0", res_data4[base], 69);
      checkOutput("s1_data1", res_data4[base + 1], 69);
      checkOutput("s1_latency", res_cyc4[base], hs1 + 2);
      checkOutput("s1_latency2", res_cyc4[base + 1], hs2 + 2);
      checkOutput("s1_period", res_cyc4[base + 1] - res_cyc4[base], 6);
    end
    checkOutput("s1_valid_cycles", ov_cnt4 - ov0, 2);

    // Full-scale operands must not truncate.
    base = res_data4.size();
    for (int i = 0; i < 4; i++) applyStimulus(0, 8'd255, 8'd255, 0);
    in_valid = 1'b0;
    waitResults(0, base + 1);
    if (res_data4.size() >= base + 1) checkOutput("max_data", res_data4[base], 260100);

    // Backpressure with input still offered.
    base = res_data4.size();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(0, ops_a[i], ops_b[i], 0);
    a = 8'd9; b = 8'd9; in_valid = 1'b1;
    h0 = hs_cnt4;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_out_valid", out_valid, 1);
      checkOutput("bp_out_data", out_data, 69);
      checkOutput("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    checkOutput("bp_no_beats", hs_cnt4, h0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_release_valid", out_valid, 0);
    checkOutput("bp_release_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 8'd1, 8'd1, 0);
    in_valid = 1'b0;
    waitResults(0, base + 2);
    if (res_data4.size() >= base + 2) begin
      checkOutput("bp_held_result", res_data4[base], 69);
      checkOutput("bp_next_set", res_data4[base + 1], 4);
    end

    // Input bubbles between beats.
    base = res_data4.size();
    for (int i = 0; i < 4; i++) applyStimulus(0, ops_a[i], ops_b[i], gaps[i]);
    in_valid = 1'b0;
    waitResults(0, base + 1);
    if (res_data4.size() >= base + 1) checkOutput("bubble_data", res_data4[base], 69);

    // Reset in the middle of a set.
    base = res_data4.size();
    applyStimulus(0, 8'd1, 8'd1, 0);
    applyStimulus(0, 8'd2, 8'd3, 0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_out_data", out_data, 0);
    checkOutput("midrst_cnt", 32'(u_dut4.cnt_q), 0);
    exp_cnt4 = 0;
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) applyStimulus(0, 8'd1, 8'd1, 0);
    in_valid = 1'b0;
    waitResults(0, base + 1);
    if (res_data4.size() >= base + 1) checkOutput("midrst_data", res_data4[base], 4);

    // LEN=1 instance: every beat is its own result.
    base1 = res_data1.size();
    applyStimulus(1, 8'd0, 8'd200, 0);
    ha = hs_cyc;
    applyStimulus(1, 8'd17, 8'd15, 0);
    hb = hs_cyc;
    in_valid1 = 1'b0;
    waitResults(1, base1 + 2);
    if (res_data1.size() >= base1 + 2) begin
      checkOutput("len1_data0", res_data1[base1], 0);
      checkOutput("len1_data1", res_data1[base1 + 1], 255);
      checkOutput("len1_lat0", res_cyc1[base1], ha + 2);
      checkOutput("len1_lat1", res_cyc1[base1 + 1], hb + 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
